// File: rtl/path_match_eliminate.sv
// path_match_eliminate
//
// Match-and-eliminate stage that sits after the insert/shift stage. It takes
// the post-insertion path and the slot of the inserted ball, grows the run of
// identical colours around that slot, and removes the run if it is long
// enough. Removal closes the gap by shifting the upper part of the path down.
// If the two balls that now meet at the join share a colour, the scan is
// repeated from the join point (chain reaction). The removed-ball count,
// chain depth and a running score are reported with the result.
//
// Ports
//   Clk          system clock, all state on the rising edge
//   Reset        synchronous, active-low reset
//   Path_in      post-insertion path, colour in [3:0], 0 = empty slot
//   Ins_idx      slot index holding the inserted ball
//   Ins_valid    one-cycle strobe qualifying Path_in / Ins_idx
//   Path_out     registered working / result path
//   Busy         high while a shot is being processed
//   Done         one-cycle pulse, Path_out is final for this shot
//   Removed_cnt  balls removed for this shot over all chain steps
//   Combo        chain steps performed for this shot (saturates at 7)
//   Score        accumulated score across shots (saturates at all ones)
//
// FSM states
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | waiting for Ins_valid, outputs hold the previous result
//   S_SCAN   | growing lo/hi one slot per side per cycle around the pivot
//   S_REMOVE | deleting slots lo..hi, shifting the upper part down
//   S_CHAIN  | checking whether the join point forms a new pivot
//   S_DONE   | raising Done / dropping Busy, then back to idle

module path_match_eliminate #(
    parameter int PATH_LEN = 26,
    parameter int MIN_RUN  = 3,
    parameter int SCORE_W  = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [PATH_LEN-1:0][9:0] Path_in,
    input  logic [4:0]               Ins_idx,
    input  logic                     Ins_valid,
    output logic [PATH_LEN-1:0][9:0] Path_out,
    output logic                     Busy,
    output logic                     Done,
    output logic [4:0]               Removed_cnt,
    output logic [2:0]               Combo,
    output logic [SCORE_W-1:0]       Score
);

    localparam logic [4:0] LAST_IDX = 5'(PATH_LEN - 1);
    localparam logic [5:0] LAST_SRC = 6'(PATH_LEN - 1);
    localparam logic [4:0] MIN_LEN  = 5'(MIN_RUN);
    // Sum is wide enough for both the score and the 8-bit bonus plus a carry.
    localparam int         SUM_W    = ((SCORE_W > 8) ? SCORE_W : 8) + 1;
    localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'({SCORE_W{1'b1}});

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_REMOVE,
        S_CHAIN,
        S_DONE
    } state_t;

    state_t                     state_q;
    logic [PATH_LEN-1:0][9:0]   path_q;
    logic [PATH_LEN-1:0][9:0]   path_d;
    logic [4:0]                 lo_q;
    logic [4:0]                 hi_q;
    logic [3:0]                 col_q;
    logic                       busy_q;
    logic                       done_q;
    logic [4:0]                 removed_q;
    logic [4:0]                 removed_d;
    logic [2:0]                 combo_q;
    logic [2:0]                 combo_d;
    logic [SCORE_W-1:0]         score_q;
    logic [SCORE_W-1:0]         score_d;

    logic [3:0]                 in_col;
    logic                       bad_shot;
    logic [4:0]                 lo_m1;
    logic [4:0]                 hi_p1;
    logic                       ext_lo;
    logic                       ext_hi;
    logic [4:0]                 run_len;
    logic [7:0]                 bonus;
    logic [SUM_W-1:0]           score_sum;
    logic                       chain_ok;
    logic [5:0]                 src;

    // Colour under the inserted ball; an out-of-range index reads as empty.
    assign in_col   = (Ins_idx <= LAST_IDX) ? Path_in[Ins_idx][3:0] : 4'd0;
    assign bad_shot = (Ins_idx > LAST_IDX) || (in_col == 4'd0);

    // Clamped neighbour indices keep every array read in range; the
    // boundary tests below decide whether the neighbour is meaningful.
    assign lo_m1 = (lo_q == 5'd0) ? 5'd0 : lo_q - 5'd1;
    assign hi_p1 = (hi_q >= LAST_IDX) ? LAST_IDX : hi_q + 5'd1;

    // col_q is never 0 while scanning, so empty slots can never match.
    assign ext_lo = (lo_q != 5'd0) && (col_q != 4'd0) &&
                    (path_q[lo_m1][3:0] == col_q);
    assign ext_hi = (hi_q < LAST_IDX) && (col_q != 4'd0) &&
                    (path_q[hi_p1][3:0] == col_q);

    assign run_len   = hi_q - lo_q + 5'd1;
    assign removed_d = removed_q + run_len;
    assign combo_d   = (combo_q == 3'd7) ? 3'd7 : combo_q + 3'd1;

    // Bonus uses the post-increment chain depth.
    assign bonus     = {3'b000, run_len} * {5'b00000, combo_d};
    assign score_sum = SUM_W'(score_q) + SUM_W'(bonus);
    assign score_d   = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}}
                                               : SCORE_W'(score_sum);

    // After removal lo points at the first ball that moved down; it joins
    // the ball at lo-1, which was not touched.
    assign chain_ok = (lo_q != 5'd0) && (path_q[lo_q][3:0] != 4'd0) &&
                      (path_q[lo_m1][3:0] == path_q[lo_q][3:0]);

    // Gap close: every slot from lo upward takes the slot run_len above it,
    // slots with no source above the top of the path become empty.
    always_comb begin
        path_d = path_q;
        src    = 6'd0;
        for (int i = 0; i < PATH_LEN; i++) begin
            src = 6'(i) + {1'b0, run_len};
            if (5'(i) >= lo_q) begin
                if (src <= LAST_SRC) begin
                    path_d[i] = path_q[src[4:0]];
                end else begin
                    path_d[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            path_q    <= '0;
            lo_q      <= 5'd0;
            hi_q      <= 5'd0;
            col_q     <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            removed_q <= 5'd0;
            combo_q   <= 3'd0;
            score_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Ins_valid) begin
                        path_q    <= Path_in;
                        lo_q      <= Ins_idx;
                        hi_q      <= Ins_idx;
                        col_q     <= in_col;
                        removed_q <= 5'd0;
                        combo_q   <= 3'd0;
                        busy_q    <= 1'b1;
                        state_q   <= bad_shot ? S_DONE : S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (ext_lo) begin
                        lo_q <= lo_q - 5'd1;
                    end
                    if (ext_hi) begin
                        hi_q <= hi_q + 5'd1;
                    end
                    if (!ext_lo && !ext_hi) begin
                        state_q <= (run_len >= MIN_LEN) ? S_REMOVE : S_DONE;
                    end
                end
                S_REMOVE: begin
                    path_q    <= path_d;
                    removed_q <= removed_d;
                    combo_q   <= combo_d;
                    score_q   <= score_d;
                    state_q   <= S_CHAIN;
                end
                S_CHAIN: begin
                    if (chain_ok) begin
                        // New pivot is the join slot; lo already sits there.
                        hi_q    <= lo_q;
                        col_q   <= path_q[lo_q][3:0];
                        state_q <= S_SCAN;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Path_out    = path_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Removed_cnt = removed_q;
    assign Combo       = combo_q;
    assign Score       = score_q;

endmodule

// File: doc/path_match_eliminate.md
# path_match_eliminate

Match-and-eliminate stage directly downstream of the insert/shift stage. It takes the 26-slot path after a shot ball has been inserted, together with the insertion slot index. It finds the run of identical colours containing that slot and, if the run is 3 or longer, removes it and closes the gap. Chain reactions repeat the process at the join point; the cleaned path and score then go to path storage and the score display.

## Interface
Parameters:
- PATH_LEN, 26, number of path slots (index 0 = exit end, index PATH_LEN-1 = entry end)
- MIN_RUN, 3, minimum run length that is eliminated
- SCORE_W, 16, score accumulator width

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-low reset
- Path_in  in  10 x [PATH_LEN]  post-insertion path; colour in bits [3:0], upper bits zero; value 0 = empty slot
- Ins_idx  in  5  slot holding the inserted ball (= 20 - Shooted_pos_X/32)
- Ins_valid  in  1  one-cycle strobe: Path_in/Ins_idx valid
- Path_out  out  10 x [PATH_LEN]  registered working/result path
- Busy  out  1  high from the cycle after accepted Ins_valid until Done
- Done  out  1  one-cycle pulse: Path_out final for this shot
- Removed_cnt  out  5  balls removed for this shot, all chain steps
- Combo  out  3  chain steps performed for this shot (0 = no elimination)
- Score  out  SCORE_W  accumulated score across shots

## Operation
- FSM states: IDLE, SCAN, REMOVE, CHAIN, DONE.
- IDLE:
  - On Ins_valid, latch Path_in into the path register and set pivot = Ins_idx, lo = hi = pivot.
  - Clear Removed_cnt and Combo; go to SCAN.
  - Ins_valid is ignored while Busy.
- Guard: if Ins_idx > PATH_LEN-1, or the colour at the pivot is 0, go straight to DONE with no change.
- SCAN:
  - Each cycle, extend lo by 1 if lo > 0 and slot[lo-1] equals the pivot colour.
  - In the same cycle, independently extend hi by 1 if hi < PATH_LEN-1 and slot[hi+1] equals the pivot colour.
  - Empty slots never match.
  - When neither side extends: len = hi-lo+1. If len >= MIN_RUN go to REMOVE, else go to DONE.
- REMOVE, single cycle:
  - slot[i] = slot[i+len] for i >= lo, provided i+len <= PATH_LEN-1.
  - The top len slots become 0; slots below lo are unchanged.
  - Removed_cnt += len; Combo += 1, saturating at 7.
  - Score += len x Combo (new Combo value), saturating at all ones.
  - Then go to CHAIN.
- CHAIN:
  - If lo > 0, slot[lo] != 0 and slot[lo-1] == slot[lo]: set pivot = lo, hi = lo, keep lo, and go to SCAN.
  - Otherwise go to DONE.
- DONE: assert Done for one cycle, then go to IDLE. Path_out, Removed_cnt and Combo hold until the next accepted shot.
- Arithmetic: len is 5 bits, max 26. The len x Combo product is 8 bits, zero-extended before the add.

## Timing
- Reset values: path register all 0, Busy 0, Done 0, Removed_cnt 0, Combo 0, Score 0, FSM in IDLE. Reset wins over everything, including mid-shot, and drops Busy in the next cycle.
- Ins_valid at cycle 0 → path latched and Busy = 1 at cycle 1.
- SCAN takes max(left extension, right extension) + 1 cycles. REMOVE takes 1 cycle and CHAIN takes 1 cycle.
- No-match shot: Done at cycle 1 + S + 1, where S = SCAN cycles.
- Busy falls in the same cycle Done rises.
- Path_out is valid whenever Done = 1. During Busy it shows intermediate contents.
- A run touching slot 0 or slot PATH_LEN-1 stops scanning at that boundary, with no wrap-around.

## Test plan
- Pure-isolation shot: Path = colour 1 at slots 0..10, colour 2 at slot 11 (Ins_idx = 11), colour 3 at slots 12..20, rest 0 → Done, path unchanged, Removed_cnt 0, Combo 0, Score unchanged.
- Simple triple: slots 0..2 = 4, slots 3..5 = 1, Ins_idx = 4 → slots 3..5 removed, remaining nonzero entries shifted down by 3, top 3 slots 0, Removed_cnt 3, Score += 3.
- Chain: slots 0..1 = 5, slots 2..4 = 2, slots 5..6 = 5, slot 7 = 6, Ins_idx = 3 → the run of 2s is removed (Combo 1, Score += 3). Then slots 0..3 = 5 are removed (Combo 2, Score += 8). slot 0 = 6, Removed_cnt 7.
- Boundaries: run at slots 23..25 with Ins_idx = 25 → slots 23..25 become 0. Ins_idx = 27 → immediate Done, no change. Pivot colour 0 → immediate Done.
- Reset mid-SCAN: Reset low during a 4-cycle scan → next cycle all outputs 0 and IDLE. A new Ins_valid is then accepted normally.
- Ins_valid pulsed while Busy → ignored; result and Score match the first shot only. Score preloaded near 65535 then a 5-ball run → Score saturates at 65535.
